// File: rtl/aes_block_receiver.sv
// UART receiver that assembles command-tagged 16-byte AES frames (key/encrypt/decrypt).
// Optional inter-byte idle timeout in COLLECT is built only when RX_FRAME_TIMEOUT_EN is defined.
//   state      | meaning
//   B_IDLE     | line idle, waiting for a falling edge
//   B_START    | mid start-bit recheck (glitch filter)
//   B_DATA     | sampling 8 data bits, LSB first
//   B_STOP     | sampling stop bit
//   F_WAIT_CMD | expecting a 'K'/'E'/'D' command byte
//   F_COLLECT  | gathering 16 payload bytes
//   F_HOLD     | frame presented on Block/Kind with Ry high
module aes_block_receiver #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Rx,
  output logic [127:0] Block,
  output logic [1:0]   Kind,
  output logic         Ry,
  input  logic         Ack,
  output logic         FrameErr,
  output logic         Overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_e;
  typedef enum logic [1:0] {F_WAIT_CMD, F_COLLECT, F_HOLD} frame_state_e;

  logic          rx_meta_q, rx_sync_q;
  bit_state_e    bit_state_q, bit_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_valid, byte_bad;

  frame_state_e  frame_state_q, frame_state_d;
  logic [3:0]    byte_cnt_q, byte_cnt_d;
  logic [127:0]  block_q, block_d;
  logic [1:0]    kind_q, kind_d;
  logic          ry_q, ry_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          tmo_expire;
  logic          in_cmd;
  logic [6:0]    byte_lsb;

  always_comb begin
    bit_state_d = bit_state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_valid  = 1'b0;
    byte_bad    = 1'b0;
    case (bit_state_q)
      B_IDLE: begin
        if (!rx_sync_q) begin
          bit_state_d = B_START;
          cnt_d       = HALF_LOAD;
        end
      end
      B_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rx_sync_q) begin
          bit_state_d = B_IDLE;
        end else begin
          bit_state_d = B_DATA;
          cnt_d       = FULL_LOAD;
          bit_idx_d   = 3'd0;
        end
      end
      B_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d   = {rx_sync_q, shift_q[7:1]};
          cnt_d     = FULL_LOAD;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) bit_state_d = B_STOP;
        end
      end
      B_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          bit_state_d = B_IDLE;
          byte_valid  = rx_sync_q;
          byte_bad    = !rx_sync_q;
        end
      end
      default: bit_state_d = B_IDLE;
    endcase
  end

`ifdef RX_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_BITS * CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Counts only idle-line cycles in COLLECT; any byte activity reloads it.
  always_comb begin
    tmo_d      = tmo_q;
    tmo_expire = 1'b0;
    if (frame_state_q != F_COLLECT || bit_state_q != B_IDLE) begin
      tmo_d = TMO_LOAD;
    end else if (tmo_q == '0) begin
      tmo_expire = 1'b1;
      tmo_d      = TMO_LOAD;
    end else begin
      tmo_d = tmo_q - TW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) tmo_q <= TMO_LOAD;
    else     tmo_q <= tmo_d;
  end
`else
  assign tmo_expire = 1'b0;
`endif

  // An Ack landing together with a byte frees the frame first, so the byte is a command.
  assign in_cmd   = (frame_state_q == F_WAIT_CMD) || (frame_state_q == F_HOLD && Ack);
  assign byte_lsb = {~byte_cnt_q, 3'b000};

  always_comb begin
    frame_state_d = frame_state_q;
    byte_cnt_d    = byte_cnt_q;
    block_d       = block_q;
    kind_d        = kind_q;
    ry_d          = ry_q;
    frame_err_d   = 1'b0;
    overrun_d     = 1'b0;
    if (frame_state_q == F_HOLD && Ack) begin
      frame_state_d = F_WAIT_CMD;
      ry_d          = 1'b0;
    end
    if (byte_bad) frame_err_d = 1'b1;
    if (tmo_expire) begin
      frame_state_d = F_WAIT_CMD;
      frame_err_d   = 1'b1;
    end
    if (byte_valid) begin
      if (in_cmd) begin
        case (shift_q)
          8'h4B: begin kind_d = 2'b00; frame_state_d = F_COLLECT; byte_cnt_d = 4'd0; end
          8'h45: begin kind_d = 2'b01; frame_state_d = F_COLLECT; byte_cnt_d = 4'd0; end
          8'h44: begin kind_d = 2'b10; frame_state_d = F_COLLECT; byte_cnt_d = 4'd0; end
          default: frame_err_d = 1'b1;
        endcase
      end else if (frame_state_q == F_COLLECT) begin
        block_d[byte_lsb +: 8] = shift_q;
        byte_cnt_d             = byte_cnt_q + 4'd1;
        if (byte_cnt_q == 4'd15) begin
          frame_state_d = F_HOLD;
          ry_d          = 1'b1;
        end
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      bit_state_q   <= B_IDLE;
      cnt_q         <= CW'(1);
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'h00;
      frame_state_q <= F_WAIT_CMD;
      byte_cnt_q    <= 4'd0;
      block_q       <= '0;
      kind_q        <= 2'b00;
      ry_q          <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      rx_meta_q     <= Rx;
      rx_sync_q     <= rx_meta_q;
      bit_state_q   <= bit_state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      frame_state_q <= frame_state_d;
      byte_cnt_q    <= byte_cnt_d;
      block_q       <= block_d;
      kind_q        <= kind_d;
      ry_q          <= ry_d;
      frame_err_q   <= frame_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign Block    = block_q;
  assign Kind     = kind_q;
  assign Ry       = ry_q;
  assign FrameErr = frame_err_q;
  assign Overrun  = overrun_q;

endmodule

// File: tb/tb_aes_block_receiver.sv
// Self-checking bench for aes_block_receiver: directed frame scenarios plus a random byte stream,
// checked against a byte-level frame model.
module tb_aes_block_receiver;
  localparam int CPB = 16;

  logic         Clk = 1'b0;
  logic         Rst, Rx, Ack;
  logic [127:0] Block;
  logic [1:0]   Kind;
  logic         Ry, FrameErr, Overrun;

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0, ov_cnt = 0;

  logic [7:0] m_bytes [16];
  int         m_n;
  bit         m_collect, m_ry;
  logic [1:0] m_kind;
  int         exp_fe = 0, exp_ov = 0;

  always #5 Clk = ~Clk;

  aes_block_receiver #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(20)) dut (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .Block(Block), .Kind(Kind),
    .Ry(Ry), .Ack(Ack), .FrameErr(FrameErr), .Overrun(Overrun)
  );

  always @(negedge Clk) begin
    if (FrameErr === 1'b1) fe_cnt++;
    if (Overrun === 1'b1) ov_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] m_block();
    logic [127:0] b = '0;
    for (int i = 0; i < 16; i++) b = {b[119:0], m_bytes[i]};
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bytes[i] = 8'h00;
    m_n = 0; m_collect = 0; m_ry = 0; m_kind = 2'b00;
  endtask

  task automatic model_byte(input logic [7:0] d, input bit stop_ok, input bit ack_same);
    if (ack_same) m_ry = 0;
    if (!stop_ok) begin exp_fe++; return; end
    if (m_ry) begin exp_ov++; return; end
    if (!m_collect) begin
      if (d == 8'h4B || d == 8'h45 || d == 8'h44) begin
        m_kind    = (d == 8'h4B) ? 2'b00 : (d == 8'h45) ? 2'b01 : 2'b10;
        m_collect = 1;
        m_n       = 0;
      end else begin
        exp_fe++;
      end
    end else begin
      m_bytes[m_n] = d;
      m_n++;
      if (m_n == 16) begin m_collect = 0; m_ry = 1; end
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_frame_err_count"}, 128'(fe_cnt), 128'(exp_fe));
    chk({tag, "_overrun_count"}, 128'(ov_cnt), 128'(exp_ov));
    chk({tag, "_ry"}, 128'(Ry), 128'(m_ry));
    if (m_ry) begin
      chk({tag, "_block"}, Block, m_block());
      chk({tag, "_kind"}, 128'(Kind), 128'(m_kind));
    end
  endtask

  // Ack pulse for one cycle aligned with the stop-bit sample when ack_same is set.
  task automatic send_byte(input logic [7:0] d, input bit stop_ok = 1, input bit ack_same = 0);
    @(negedge Clk) Rx = 1'b0;
    repeat (CPB) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      Rx = d[i];
      repeat (CPB) @(negedge Clk);
    end
    Rx = stop_ok;
    if (ack_same) begin
      repeat (10) @(negedge Clk);
      Ack = 1'b1;
      @(negedge Clk);
      Ack = 1'b0;
      repeat (CPB - 11) @(negedge Clk);
    end else begin
      repeat (CPB) @(negedge Clk);
    end
    Rx = 1'b1;
    repeat (20) @(negedge Clk);
    model_byte(d, stop_ok, ack_same);
    check_state("byte");
  endtask

  task automatic ack_frame();
    @(negedge Clk);
    chk("ry_before_ack", 128'(Ry), 128'(1));
    Ack = 1'b1;
    @(negedge Clk);
    Ack = 1'b0;
    chk("ry_after_ack", 128'(Ry), 128'(0));
    m_ry = 0;
  endtask

  initial begin
    logic [7:0] d;
    logic [127:0] snap;
    bit ok;
    Rst = 1'b1; Rx = 1'b1; Ack = 1'b0;
    model_reset();
    repeat (3) @(negedge Clk);
    chk("reset_block", Block, '0);
    chk("reset_kind", 128'(Kind), 128'(0));
    chk("reset_ry", 128'(Ry), 128'(0));
    chk("reset_ferr", 128'(FrameErr), 128'(0));
    chk("reset_ovr", 128'(Overrun), 128'(0));
    Rst = 1'b0;
    repeat (5) @(negedge Clk);

    // encrypt frame with 00..0F, held until acknowledged
    send_byte(8'h45);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    chk("enc_block", Block, 128'h000102030405060708090A0B0C0D0E0F);
    chk("enc_kind", 128'(Kind), 128'(1));
    repeat (50) @(negedge Clk);
    chk("enc_ry_hold", 128'(Ry), 128'(1));
    ack_frame();

    // stray Ack with no frame pending
    Ack = 1'b1; @(negedge Clk); Ack = 1'b0;
    repeat (3) @(negedge Clk);
    chk("stray_ack_ry", 128'(Ry), 128'(0));

    // bad command then key frame of all ones
    send_byte(8'h5A);
    send_byte(8'h4B);
    for (int i = 0; i < 16; i++) send_byte(8'hFF);
    chk("key_block", Block, {128{1'b1}});
    chk("key_kind", 128'(Kind), 128'(0));

    // overrun while held, then a short glitch
    snap = Block;
    send_byte(8'h11);
    chk("overrun_block_kept", Block, snap);
    @(negedge Clk) Rx = 1'b0;
    repeat (4) @(negedge Clk);
    Rx = 1'b1;
    repeat (40) @(negedge Clk);
    check_state("glitch");

    // Ack together with a command byte's stop sample
    send_byte(8'h44, 1, 1);
    for (int i = 0; i < 16; i++) send_byte(8'($urandom_range(0, 255)));
    chk("ack_same_kind", 128'(Kind), 128'(2));
    ack_frame();

    // stop-bit error mid-frame does not advance the byte count
    send_byte(8'h45);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)));
    send_byte(8'h77, 0);
    for (int i = 0; i < 13; i++) send_byte(8'($urandom_range(0, 255)));
    chk("stop_err_ry", 128'(Ry), 128'(1));
    ack_frame();

    // reset mid-frame, then a fresh decrypt frame
    send_byte(8'h44);
    for (int i = 0; i < 7; i++) send_byte(8'($urandom_range(1, 255)));
    @(negedge Clk) Rst = 1'b1;
    @(negedge Clk);
    chk("midrst_block", Block, '0);
    chk("midrst_kind", 128'(Kind), 128'(0));
    chk("midrst_ry", 128'(Ry), 128'(0));
    chk("midrst_ferr", 128'(FrameErr), 128'(0));
    chk("midrst_ovr", 128'(Overrun), 128'(0));
    Rst = 1'b0;
    model_reset();
    repeat (5) @(negedge Clk);
    send_byte(8'h44);
    for (int i = 0; i < 16; i++) send_byte(8'hA5);
    chk("dec_block", Block, {16{8'hA5}});
    chk("dec_kind", 128'(Kind), 128'(2));
    ack_frame();

    // long idle inside COLLECT
    send_byte(8'h45);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)));
    repeat (20 * CPB + 40) @(negedge Clk);
`ifdef RX_FRAME_TIMEOUT_EN
    exp_fe++;
    m_collect = 0;
`endif
    check_state("idle");
    for (int i = 0; i < 11; i++) send_byte(8'($urandom_range(0, 255)));
    if (m_ry) ack_frame();

    // random byte stream
    for (int i = 0; i < 60; i++) begin
      if (!m_collect && !m_ry && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 2))
          0: d = 8'h4B;
          1: d = 8'h45;
          default: d = 8'h44;
        endcase
      end else begin
        d = 8'($urandom_range(0, 255));
      end
      ok = ($urandom_range(0, 9) != 0);
      send_byte(d, ok);
      if (m_ry && $urandom_range(0, 1) == 1) ack_frame();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
